// File: rtl/instr_fetch.sv
// Instruction fetch controller: issues one memory read at a time, holds the result
// for decode, and converts execute redirects into program-counter select codes.
module instr_fetch #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic [1:0]         ps,
  output logic [ADDR_W-1:0]  pc_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               br_valid,
  input  logic               br_mode,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               id_ready
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] PS_STALL = 2'b00;
  localparam logic [1:0] PS_INCR  = 2'b01;

  state_t     state, state_nx;
  logic [1:0] ps_raw;
  logic       load_addr;
  logic       load_ir;
  logic       clr_irv;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ISSUE;
      mem_addr <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_addr) mem_addr <= pc;
      if (load_ir) begin
        ir       <= mem_rdata;
        ir_pc    <= mem_addr;
        ir_valid <= 1'b1;
      end else if (clr_irv) begin
        ir_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    ps_raw    = PS_STALL;
    load_addr = 1'b0;
    load_ir   = 1'b0;
    clr_irv   = br_valid;
    case (state)
      ISSUE: begin
        if (!br_valid) begin
          load_addr = 1'b1;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (br_valid) begin
          state_nx = mem_ack ? ISSUE : DRAIN;
        end else if (mem_ack) begin
          load_ir  = 1'b1;
          ps_raw   = PS_INCR;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // An empty HOLD cannot wait for decode, so it refetches.
        if (br_valid || !ir_valid) begin
          state_nx = ISSUE;
        end else if (id_ready) begin
          clr_irv  = 1'b1;
          state_nx = ISSUE;
        end
      end
      DRAIN: begin
        if (mem_ack) state_nx = ISSUE;
      end
      default: state_nx = ISSUE;
    endcase
    if (br_valid) ps_raw = {1'b1, br_mode};
  end

  assign mem_req = reset && ((state == WAIT) || (state == DRAIN));
  assign ps      = reset ? ps_raw : PS_STALL;
  assign pc_in   = (reset && br_valid) ? br_target : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Vector-table bench for instr_fetch; each vector's expectations go through a
// scoreboard queue and are checked before (combinational) and after (registered) the edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [1:0]  ps;
  logic [63:0] pc_in;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        br_valid;
  logic        br_mode;
  logic [63:0] br_target;
  logic        ir_valid;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        id_ready;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.ADDR_W(64), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ps(ps), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .br_valid(br_valid), .br_mode(br_mode), .br_target(br_target),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        brv;
    logic        brm;
    logic [63:0] brt;
    logic        idr;
    logic [1:0]  e_ps;
    logic [63:0] e_pcin;
    logic        e_req;
    logic        e_irv;
    logic [31:0] e_ir;
    logic [63:0] e_irpc;
    logic [63:0] e_addr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic rst, logic [63:0] p, logic ack, logic [31:0] rd,
                              logic brv, logic brm, logic [63:0] brt, logic idr,
                              logic [1:0] eps, logic [63:0] epcin, logic ereq,
                              logic eirv, logic [31:0] eir, logic [63:0] eirpc,
                              logic [63:0] eaddr);
    vec_t v;
    v.rst = rst; v.pc = p; v.ack = ack; v.rdata = rd;
    v.brv = brv; v.brm = brm; v.brt = brt; v.idr = idr;
    v.e_ps = eps; v.e_pcin = epcin; v.e_req = ereq;
    v.e_irv = eirv; v.e_ir = eir; v.e_irpc = eirpc; v.e_addr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    reset = v.rst; pc = v.pc; mem_ack = v.ack; mem_rdata = v.rdata;
    br_valid = v.brv; br_mode = v.brm; br_target = v.brt; id_ready = v.idr;
    sb.push_back(v);
    #3;
    e = sb[0];
    chk("ps", idx, {62'd0, ps}, {62'd0, e.e_ps});
    chk("pc_in", idx, pc_in, e.e_pcin);
    chk("mem_req", idx, {63'd0, mem_req}, {63'd0, e.e_req});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ir_valid", idx, {63'd0, ir_valid}, {63'd0, e.e_irv});
    chk("ir", idx, {32'd0, ir}, {32'd0, e.e_ir});
    chk("ir_pc", idx, ir_pc, e.e_irpc);
    chk("mem_addr", idx, mem_addr, e.e_addr);
  endtask

  localparam logic [31:0] D1 = 32'hA5A5_0001;
  localparam logic [31:0] D2 = 32'h1234_5678;
  localparam logic [31:0] D3 = 32'hCAFE_0001;
  localparam logic [31:0] D4 = 32'h0F0F_0F0F;

  initial begin
    reset = 1'b0; pc = '0; mem_ack = 1'b0; mem_rdata = '0;
    br_valid = 1'b0; br_mode = 1'b0; br_target = '0; id_ready = 1'b0;

    // rst pc ack rdata brv brm brt idr | ps pc_in req | irv ir ir_pc mem_addr
    // reset forces outputs idle whatever the inputs
    tbl.push_back(mk(0, 64'h9, 1, 32'hFFFF, 1, 0, 64'h77, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    // basic fetch; stale ack in ISSUE ignored, ack 2 cycles after mem_req
    tbl.push_back(mk(1, 0, 1, 32'hBAD, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, D1, 0, 0, 0, 0, 2'b01, 0, 1, 1, D1, 0, 0));
    // decode back-pressure for 5 cycles
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, D1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, D1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, D1, 0, 1));
    // branch mid-request, then a second redirect while draining
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 64'h40, 0, 2'b10, 64'h40, 1, 0, D1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, D1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 64'h8, 0, 2'b11, 64'h8, 1, 0, D1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 32'hDEAD, 0, 0, 0, 0, 2'b00, 0, 1, 0, D1, 0, 1));
    tbl.push_back(mk(1, 64'h40, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, D1, 0, 64'h40));
    // branch coincident with ack
    tbl.push_back(mk(1, 64'h40, 1, 32'hBEEF, 1, 1, 64'h8, 0, 2'b11, 64'h8, 1, 0, D1, 0, 64'h40));
    tbl.push_back(mk(1, 64'h48, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, D1, 0, 64'h48));
    tbl.push_back(mk(1, 64'h48, 1, D2, 0, 0, 0, 0, 2'b01, 0, 1, 1, D2, 64'h48, 64'h48));
    // flush in HOLD without decode, then a redirect held in ISSUE
    tbl.push_back(mk(1, 64'h48, 0, 0, 1, 0, 64'h100, 0, 2'b10, 64'h100, 0, 0, D2, 64'h48, 64'h48));
    tbl.push_back(mk(1, 64'h48, 0, 0, 1, 1, 64'h4, 0, 2'b11, 64'h4, 0, 0, D2, 64'h48, 64'h48));
    tbl.push_back(mk(1, 64'h100, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, D2, 64'h48, 64'h100));
    tbl.push_back(mk(1, 64'h100, 1, D3, 0, 0, 0, 0, 2'b01, 0, 1, 1, D3, 64'h100, 64'h100));
    // redirect coinciding with a decode transfer
    tbl.push_back(mk(1, 64'h100, 0, 0, 1, 1, 64'h10, 1, 2'b11, 64'h10, 0, 0, D3, 64'h100, 64'h100));
    tbl.push_back(mk(1, 64'h200, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, D3, 64'h100, 64'h200));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset while a request is outstanding, then a stale ack and a fresh fetch.
    apply(mk(1, 64'h200, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, D3, 64'h100, 64'h200), 100);
    apply(mk(0, 64'h200, 0, 0, 1, 1, 64'h55, 1, 2'b00, 0, 0, 0, 0, 0, 0), 101);
    apply(mk(1, 64'h300, 1, 32'hBAD, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 64'h300), 102);
    apply(mk(1, 64'h300, 1, D4, 0, 0, 0, 0, 2'b01, 0, 1, 1, D4, 64'h300, 64'h300), 103);
    apply(mk(1, 64'h301, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, D4, 64'h300, 64'h300), 104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
